// File: rtl/song_sequencer.sv
// Song step sequencer: advances songpos on frame ticks, emits step/instrument
// trigger pulses and drives decaying kick/snare envelopes.
module song_sequencer #(
    parameter int         FRAMES_PER_STEP = 8,
    parameter logic [7:0] LOOP_START      = 8'h40,
    parameter logic [3:0] ENV_MAX         = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       restart,
    input  logic       rom_kick,
    input  logic       rom_snare,
    input  logic       rom_pulse,
    output logic [7:0] songpos,
    output logic       arpidx,
    output logic       step_strobe,
    output logic       kick_trig,
    output logic       snare_trig,
    output logic       pulse_trig,
    output logic [3:0] kick_env,
    output logic [3:0] snare_env,
    output logic       playing
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [3:0] FCNT_LAST = 4'(FRAMES_PER_STEP - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] songpos_q, songpos_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic [1:0] arpcnt_q, arpcnt_d;
    logic       arpidx_q, arpidx_d;
    logic       step_strobe_q, step_strobe_d;
    logic       kick_trig_q, kick_trig_d;
    logic       snare_trig_q, snare_trig_d;
    logic       pulse_trig_q, pulse_trig_d;
    logic [3:0] kick_env_q, kick_env_d;
    logic [3:0] snare_env_q, snare_env_d;

    // A fresh trigger reloads the envelope even if a frame tick lands in the same cycle.
    function automatic logic [3:0] env_next(input logic load, input logic tick,
                                            input logic [3:0] env);
        if (load)
            return ENV_MAX;
        else if (tick && (env != 4'd0))
            return env - 4'd1;
        else
            return env;
    endfunction

    always_comb begin
        state_d       = state_q;
        songpos_d     = songpos_q;
        fcnt_d        = fcnt_q;
        arpcnt_d      = arpcnt_q;
        arpidx_d      = arpidx_q;
        step_strobe_d = 1'b0;
        kick_trig_d   = step_strobe_q & rom_kick;
        snare_trig_d  = step_strobe_q & rom_snare;
        pulse_trig_d  = step_strobe_q & rom_pulse;

        if (restart || (state_q == S_IDLE && run)) begin
            state_d       = S_PLAY;
            songpos_d     = 8'd0;
            fcnt_d        = 4'd0;
            arpcnt_d      = 2'd0;
            arpidx_d      = 1'b0;
            step_strobe_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_PLAY: begin
                    if (!run) begin
                        state_d = S_HOLD;
                    end else if (frame_tick) begin
                        arpcnt_d = arpcnt_q + 2'd1;
                        if (arpcnt_q == 2'd3)
                            arpidx_d = ~arpidx_q;
                        if (fcnt_q == FCNT_LAST) begin
                            fcnt_d        = 4'd0;
                            songpos_d     = (songpos_q == 8'hFF) ? LOOP_START : songpos_q + 8'd1;
                            step_strobe_d = 1'b1;
                        end else begin
                            fcnt_d = fcnt_q + 4'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (run)
                        state_d = S_PLAY;
                end
                default: state_d = S_IDLE;
            endcase
        end

        kick_env_d  = env_next(kick_trig_d, frame_tick, kick_env_q);
        snare_env_d = env_next(snare_trig_d, frame_tick, snare_env_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            songpos_q     <= 8'd0;
            fcnt_q        <= 4'd0;
            arpcnt_q      <= 2'd0;
            arpidx_q      <= 1'b0;
            step_strobe_q <= 1'b0;
            kick_trig_q   <= 1'b0;
            snare_trig_q  <= 1'b0;
            pulse_trig_q  <= 1'b0;
            kick_env_q    <= 4'd0;
            snare_env_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            songpos_q     <= songpos_d;
            fcnt_q        <= fcnt_d;
            arpcnt_q      <= arpcnt_d;
            arpidx_q      <= arpidx_d;
            step_strobe_q <= step_strobe_d;
            kick_trig_q   <= kick_trig_d;
            snare_trig_q  <= snare_trig_d;
            pulse_trig_q  <= pulse_trig_d;
            kick_env_q    <= kick_env_d;
            snare_env_q   <= snare_env_d;
        end
    end

    assign songpos     = songpos_q;
    assign arpidx      = arpidx_q;
    assign step_strobe = step_strobe_q;
    assign kick_trig   = kick_trig_q;
    assign snare_trig  = snare_trig_q;
    assign pulse_trig  = pulse_trig_q;
    assign kick_env    = kick_env_q;
    assign snare_env   = snare_env_q;
    assign playing     = (state_q == S_PLAY);

endmodule
